// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: IRAM/datapath bundle between the fetch sequencer (master) and its environment (slave).
interface fetch_sequencer_if;
    logic        start;
    logic [19:0] instr_in;
    logic        z_flag;
    logic        exec_done;
    logic [5:0]  pc;
    logic        exec_req;
    logic [3:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [11:0] addr12;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
    modport master (
        input  start, instr_in, z_flag, exec_done,
        output pc, exec_req, opcode, ra, rb, addr12, busy, halted, retired
    );
    modport slave (
        output start, instr_in, z_flag, exec_done,
        input  pc, exec_req, opcode, ra, rb, addr12, busy, halted, retired
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/FETCH/DECODE/EXEC/HALT sequencer; control ops retire in DECODE, datapath ops wait for exec_done.
module fetch_sequencer (
    input  logic clk,
    input  logic rst,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
    state_t      state;
    logic [5:0]  pc;
    logic [19:0] ir;
    logic        exec_req;
    logic [15:0] retired;
    logic [3:0]  op;
    logic [5:0]  pc_inc;
    logic [15:0] ret_inc;
    assign op      = bus.instr_in[19:16];
    assign pc_inc  = pc + 6'd1;
    assign ret_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            exec_req <= 1'b0;
            retired  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= FETCH;
                    pc    <= '0;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    // instr_in is the IRAM word registered on the FETCH->DECODE edge
                    if (op == 4'hC || (op == 4'hB && bus.z_flag)) begin
                        pc      <= bus.instr_in[15:10];
                        retired <= ret_inc;
                        state   <= FETCH;
                    end else if (op == 4'hE) begin
                        retired <= ret_inc;
                        state   <= HALT;
                    end else if (op inside {4'h0, 4'h1, 4'hB, 4'hF}) begin
                        pc      <= pc_inc;
                        retired <= ret_inc;
                        state   <= FETCH;
                    end else begin
                        ir       <= bus.instr_in;
                        exec_req <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: if (bus.exec_done) begin
                    exec_req <= 1'b0;
                    pc       <= pc_inc;
                    retired  <= ret_inc;
                    state    <= FETCH;
                end
                default: ;
            endcase
        end
    end
    assign bus.pc       = pc;
    assign bus.exec_req = exec_req;
    assign bus.opcode   = ir[19:16];
    assign bus.ra       = ir[15:12];
    assign bus.rb       = ir[11:8];
    assign bus.addr12   = ir[11:0];
    assign bus.retired  = retired;
    assign bus.busy     = state inside {FETCH, DECODE, EXEC};
    assign bus.halted   = state == HALT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random programs scored against an instruction-level model.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    fetch_sequencer_if sif();
    fetch_sequencer dut (.clk(clk), .rst(rst), .bus(sif));

    always #5 clk = ~clk;

    logic [19:0] ram [64];
    always @(posedge clk) sif.instr_in <= ram[sif.pc];

    int checks = 0;
    int errors = 0;
    int done_pct = 0;
    int lim = 0;
    bit chk = 1'b0;
    bit z = 1'b0;
    bit exp_halt;
    logic [5:0] halt_pc;
    bit seen_req;
    logic [22:0] rq [$];
    logic [29:0] eq [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
    endtask

    task automatic wait_ret(input int n, input string nm);
        int c = 0;
        while (sif.retired < 16'(n) && !sif.halted && c < 200) begin
            tick();
            if (sif.exec_req) seen_req = 1'b1;
            c++;
        end
        if (c >= 200) check({nm, "_timeout"}, 32'(c), 32'd0);
    endtask

    task automatic wait_req(input string nm);
        int c = 0;
        while (!sif.exec_req && c < 100) begin
            tick();
            c++;
        end
        if (c >= 100) check({nm, "_timeout"}, 32'(c), 32'd0);
    endtask

    // Instruction-level reference: walks the program and lists every retirement and datapath issue
    task automatic model(input int limit);
        logic [5:0] p = '0;
        int n = 0;
        logic [19:0] w;
        logic [3:0] op;
        rq.delete();
        eq.delete();
        exp_halt = 1'b0;
        while (n < limit) begin
            w = ram[p];
            op = w[19:16];
            n++;
            if (op == 4'hE) begin
                rq.push_back({1'b1, p, 16'(n)});
                exp_halt = 1'b1;
                halt_pc = p;
                break;
            end
            if (op == 4'hC || (op == 4'hB && z)) p = w[15:10];
            else begin
                if (!(op inside {4'h0, 4'h1, 4'hB, 4'hF})) eq.push_back({p, w, w[11:8]});
                p = p + 6'd1;
            end
            rq.push_back({1'b0, p, 16'(n)});
        end
    endtask

    initial begin
        sif.exec_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sif.exec_done = ($urandom_range(99) < done_pct);
        end
    end

    logic [15:0] last_ret = '0;
    bit prev_req = 1'b0;
    bit prev_rst = 1'b1;
    always @(negedge clk) begin
        if (chk && !prev_rst) begin
            if (sif.retired != last_ret) begin
                if (rq.size() == 0) check("retire_extra", 32'(sif.retired), 32'(last_ret));
                else check("retire", 32'({sif.halted, sif.pc, sif.retired}), 32'(rq.pop_front()));
            end
            if (sif.exec_req && !prev_req && sif.retired < 16'(lim)) begin
                if (eq.size() == 0) check("exec_extra", 32'(sif.pc), 32'h3f_ffff);
                else check("exec", {2'b0, sif.pc, sif.opcode, sif.ra, sif.addr12, sif.rb}, 32'(eq.pop_front()));
            end
        end
        last_ret = sif.retired;
        prev_req = sif.exec_req;
        prev_rst = rst;
    end

    initial begin
        bit ok;
        int c;
        sif.start = 1'b0;
        sif.z_flag = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = 20'hE0000;
        do_rst();
        check("rst_pc", 32'(sif.pc), 0);
        check("rst_flags", 32'({sif.exec_req, sif.busy, sif.halted}), 0);
        check("rst_fields", 32'({sif.opcode, sif.ra, sif.rb, sif.addr12}), 0);
        check("rst_retired", 32'(sif.retired), 0);

        ram[0] = 20'h31000; ram[1] = 20'hC8C00; ram[35] = 20'hC3000; ram[12] = 20'hC5000;
        ram[20] = 20'hB8400; ram[33] = 20'hC8000; ram[32] = 20'hE0000; ram[21] = 20'hE0000;
        sif.z_flag = 1'b1;
        start_pulse();
        tick();
        tick();
        check("first_exec", 32'({sif.exec_req, sif.pc, sif.opcode, sif.ra, sif.addr12}), {7'd0, 1'b1, 6'd0, 4'd3, 4'd1, 12'd0});
        check("first_busy", 32'(sif.busy), 1);
        done_pct = 100;
        wait_ret(1, "ret1");
        check("ret1_pc", 32'({sif.pc, sif.retired}), {6'd1, 16'd1});
        seen_req = 1'b0;
        wait_ret(3, "jmp");
        check("jmp_pc", 32'(sif.pc), 12);
        wait_ret(5, "jmpz1");
        check("jmpz_taken", 32'(sif.pc), 33);
        check("ctrl_no_req", 32'(seen_req), 0);
        wait_ret(7, "end1");
        check("halt_state", 32'({sif.halted, sif.busy, sif.pc, sif.retired}), {1'b1, 1'b0, 6'd32, 16'd7});
        start_pulse();
        start_pulse();
        tick();
        check("halt_hold", 32'({sif.halted, sif.busy, sif.pc, sif.retired}), {1'b1, 1'b0, 6'd32, 16'd7});
        do_rst();
        check("halt_rst", 32'({sif.halted, sif.pc, sif.retired}), 0);

        sif.z_flag = 1'b0;
        start_pulse();
        wait_ret(5, "jmpz0");
        check("jmpz_not_taken", 32'(sif.pc), 21);
        wait_ret(6, "end2");
        check("halt2", 32'({sif.halted, sif.pc}), {1'b1, 6'd21});

        ram[0] = 20'hCFC00; ram[63] = 20'h52345;
        do_rst();
        done_pct = 0;
        start_pulse();
        wait_req("wrap_req");
        check("wrap_exec", 32'({sif.pc, sif.opcode, sif.ra, sif.rb}), {6'd63, 4'h5, 4'h2, 4'h3});
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (!sif.exec_req || sif.pc != 6'd63 || sif.retired != 16'd1) ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 1);
        done_pct = 100;
        wait_ret(2, "wrap");
        check("wrap_pc", 32'({sif.pc, sif.exec_req}), {6'd0, 1'b0});
        done_pct = 0;
        wait_req("abort_req");
        do_rst();
        check("abort_rst", 32'({sif.exec_req, sif.busy, sif.pc, sif.retired, sif.opcode}), 0);
        done_pct = 100;
        repeat (5) tick();
        check("abort_idle", 32'({sif.exec_req, sif.busy, sif.pc, sif.retired}), 0);

        for (int r = 0; r < 25; r++) begin
            chk = 1'b0;
            do_rst();
            lim = 40;
            z = 1'($urandom);
            sif.z_flag = z;
            done_pct = $urandom_range(100, 20);
            for (int i = 0; i < 64; i++) ram[i] = {4'($urandom_range(15)), 16'($urandom)};
            model(lim);
            chk = 1'b1;
            start_pulse();
            c = 0;
            while (sif.retired < 16'(lim) && !sif.halted && c < 3000) begin
                tick();
                c++;
            end
            if (c >= 3000) check("run_timeout", 32'(c), 0);
            if (exp_halt) begin
                start_pulse();
                tick();
                check("rand_halt", 32'({sif.halted, sif.busy, sif.pc}), {1'b1, 1'b0, halt_pc});
            end
            tick();
            check("rq_drained", 32'(rq.size()), 0);
            check("eq_drained", 32'(eq.size()), 0);
        end
        chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or async input is permitted.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  begin execution from PC 0; honoured only in IDLE.
REQ-005 instr_in  input  20  instruction word from IRAM; valid one cycle after pc is presented (IRAM registers ram[pc] on posedge clk).
REQ-006 z_flag  input  1  datapath zero flag from last SUB; consulted by JMPZ.
REQ-007 exec_done  input  1  datapath completion for the current exec_req.
REQ-008 pc  output  6  instruction address to IRAM.
REQ-009 exec_req  output  1  registered; high while a datapath instruction awaits completion.
REQ-010 opcode  output  4  ir[19:16] of the held instruction.
REQ-011 ra  output  4  ir[15:12].
REQ-012 rb  output  4  ir[11:8].
REQ-013 addr12  output  12  ir[11:0] (LOADI address / immediate).
REQ-014 busy  output  1  high in any state except IDLE and HALT.
REQ-015 halted  output  1  high in HALT.
REQ-016 retired  output  16  count of completed instructions, saturating at 0xFFFF.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXEC, HALT.
REQ-018 IDLE: start=1 -> FETCH with pc=0; start ignored in every other state.
REQ-019 FETCH: pc held stable for one cycle -> DECODE unconditionally.
REQ-020 DECODE: instr_in opcode[19:16] evaluated combinationally in that cycle.
- 1100 JMP: pc <= instr_in[15:10]; retired+1; -> FETCH.
- 1011 JMPZ: z_flag=1 -> pc <= instr_in[15:10], else pc <= pc+1; retired+1; -> FETCH.
- 1110 END: pc unchanged; retired+1; -> HALT.
- 0000, 0001, 1111: NOP; pc <= pc+1; retired+1; -> FETCH.
- All other opcodes: ir <= instr_in; exec_req <= 1; -> EXEC.
REQ-021 opcode/ra/rb/addr12 SHALL reflect ir and change only when ir is loaded in DECODE.
REQ-022 EXEC: on exec_done=1 (already valid in the first EXEC cycle), exec_req <= 0, pc <= pc+1, retired+1, -> FETCH; otherwise hold all outputs.
REQ-023 exec_done outside EXEC SHALL be ignored.
REQ-024 pc+1 SHALL wrap modulo 64 (63 -> 0).
REQ-025 Minimum cost: 2 cycles per control op, 3 cycles per datapath op (FETCH, DECODE, EXEC).
REQ-026 HALT: all outputs held, start ignored; only rst exits HALT.
REQ-027 retired SHALL hold at 0xFFFF once reached.

Reset
REQ-028 On a clk edge with rst=1, regardless of state, the block SHALL enter IDLE with pc=0, ir=0, opcode/ra/rb/addr12=0, exec_req=0, busy=0, halted=0 and retired=0.
REQ-029 rst SHALL take priority over start and exec_done in the same cycle.
REQ-030 A pending exec_req abandoned by reset SHALL NOT be reissued; the datapath sees exec_req=0 from the cycle after the reset edge.

Verification
REQ-031 rst, then start with ram[0]=0x31000 -> FETCH with pc=0, exec_req=1 two edges after the start edge with opcode=3, ra=1, addr12=0x000; exec_done -> pc=1, retired=1.
REQ-032 pc=35 holding 0xC3000 (JMP 12) -> pc=12 after DECODE, exec_req never asserted, retired+1.
REQ-033 pc=20 holding 0xB8400 (JMPZ 33): z_flag=1 -> pc=33; rerun with z_flag=0 -> pc=21.
REQ-034 pc=32 holding 0xE0000 (END) -> halted=1, busy=0, pc=32 held; start pulses ignored; rst -> pc=0, halted=0, retired=0.
REQ-035 pc=63 holding a datapath op, exec_done=1 -> pc wraps to 0; exec_done held low for 10 cycles -> exec_req stays high and pc stays 63.
REQ-036 rst asserted in EXEC with exec_done=0 -> next cycle exec_req=0, IDLE, pc=0; a later exec_done=1 with no start causes no state change.
